// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU
// load/store path and the debug/loader port. Round-robin on ties,
// registered memory command, read data steered back by a 1-bit tag.
module dmem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // debug/loader port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          mem_rden,
  input  logic [DW-1:0] mem_q
);

  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;

  logic       last_grant;
  // [0]: read issued this cycle, [1]: read data on mem_q this cycle
  logic [1:0] vld_pipe;
  logic [1:0] tag_pipe;
  logic       c_elig, d_elig, win_c, win_d;

  // Pick a winner; a port whose gnt is high this cycle is not eligible,
  // so a held request is never issued twice.
  always_comb begin
    c_elig = c_req & ~c_gnt;
    d_elig = d_req & ~d_gnt;
    win_c  = c_elig & (~d_elig | (last_grant == DBG));
    win_d  = d_elig & ~win_c;
  end

  // Register the memory command, grants and the read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      last_grant <= DBG;
      vld_pipe   <= '0;
      tag_pipe   <= '0;
    end else begin
      c_gnt       <= win_c;
      d_gnt       <= win_d;
      mem_wren    <= 1'b0;
      mem_rden    <= 1'b0;
      vld_pipe[0] <= 1'b0;
      if (win_c) begin
        mem_addr    <= c_addr;
        mem_wdata   <= c_wdata;
        mem_wren    <= c_we;
        mem_rden    <= ~c_we;
        vld_pipe[0] <= ~c_we;
        tag_pipe[0] <= CPU;
        last_grant  <= CPU;
      end else if (win_d) begin
        mem_addr    <= d_addr;
        mem_wdata   <= d_wdata;
        mem_wren    <= d_we;
        mem_rden    <= ~d_we;
        vld_pipe[0] <= ~d_we;
        tag_pipe[0] <= DBG;
        last_grant  <= DBG;
      end
      vld_pipe[1] <= vld_pipe[0];
      tag_pipe[1] <= tag_pipe[0];
    end
  end

  // Steer returning read data to its requester; the other port sees 0.
  always_comb begin
    c_rvalid = vld_pipe[1] & (tag_pipe[1] == CPU);
    d_rvalid = vld_pipe[1] & (tag_pipe[1] == DBG);
    c_rdata  = c_rvalid ? mem_q : '0;
    d_rdata  = d_rvalid ? mem_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1K-word registered-read memory model.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren, mem_rden;
  logic [DW-1:0] mem_q;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  // Single-port memory, read data valid the cycle after mem_rden; preloaded in reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[16] <= 32'hDEADBEEF;
      mem[1]  <= 32'hA5A50001;
      mem_q   <= '0;
    end else begin
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      if (mem_rden) mem_q <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    #2;

    // reset state
    tick();
    chk("rst_c_gnt",   c_gnt, 0);
    chk("rst_d_gnt",   d_gnt, 0);
    chk("rst_c_rv",    c_rvalid, 0);
    chk("rst_mem_en",  {mem_wren, mem_rden}, 0);
    chk("rst_addr",    mem_addr, 0);
    chk("rst_wdata",   mem_wdata, 0);
    rst = 1'b0;

    // single CPU read of 0x010
    c_req = 1; c_we = 0; c_addr = 10'h010;
    tick();
    chk("t1_c_gnt", c_gnt, 1);
    chk("t1_rden",  mem_rden, 1);
    chk("t1_wren",  mem_wren, 0);
    chk("t1_addr",  mem_addr, 10'h010);
    chk("t1_d_gnt", d_gnt, 0);
    c_req = 0;
    tick();
    chk("t1_c_rv",   c_rvalid, 1);
    chk("t1_c_rd",   c_rdata, 32'hDEADBEEF);
    chk("t1_d_rv",   d_rvalid, 0);
    chk("t1_d_rd",   d_rdata, 0);
    chk("t1_c_gnt2", c_gnt, 0);

    // simultaneous requests from reset: CPU first, then debug
    do_reset();
    c_req = 1; c_we = 0; c_addr = 10'h001;
    d_req = 1; d_we = 1; d_addr = 10'h002; d_wdata = 32'h55;
    tick();
    chk("t2_c_gnt", c_gnt, 1);
    chk("t2_d_gnt", d_gnt, 0);
    chk("t2_addr0", mem_addr, 10'h001);
    c_req = 0;
    tick();
    chk("t2_d_gnt1", d_gnt, 1);
    chk("t2_wren",   mem_wren, 1);
    chk("t2_addr1",  mem_addr, 10'h002);
    chk("t2_wdata",  mem_wdata, 32'h55);
    chk("t2_c_rv",   c_rvalid, 1);
    chk("t2_c_rd",   c_rdata, 32'hA5A50001);
    d_req = 0;
    tick();
    chk("t2_idle_en", {mem_wren, mem_rden}, 0);
    chk("t2_no_rv",   {c_rvalid, d_rvalid}, 0);
    chk("t2_mem2",    mem[2], 32'h55);

    // continuous contention: strict alternation starting with CPU
    c_req = 1; c_we = 0; c_addr = 10'h010;
    d_req = 1; d_we = 0; d_addr = 10'h001;
    for (int k = 0; k < 8; k++) begin
      logic prev_c, prev_d;
      prev_c = c_gnt; prev_d = d_gnt;
      tick();
      chk($sformatf("t3_c_gnt%0d", k), c_gnt, (k % 2 == 0));
      chk($sformatf("t3_d_gnt%0d", k), d_gnt, (k % 2 == 1));
      chk($sformatf("t3_one_en%0d", k), mem_wren + mem_rden, 1);
      if (k > 0) begin
        chk($sformatf("t3_c_rv%0d", k), c_rvalid, prev_c);
        chk($sformatf("t3_d_rv%0d", k), d_rvalid, prev_d);
      end
    end
    c_req = 0; d_req = 0;
    tick();
    tick();

    // write-then-read ordering on 0x3FF
    d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'h12345678;
    tick();
    chk("t4_d_gnt", d_gnt, 1);
    chk("t4_wren",  mem_wren, 1);
    d_req = 0;
    c_req = 1; c_we = 0; c_addr = 10'h3FF;
    tick();
    chk("t4_c_gnt", c_gnt, 1);
    chk("t4_rden",  mem_rden, 1);
    chk("t4_addr",  mem_addr, 10'h3FF);
    c_req = 0;
    tick();
    chk("t4_c_rv", c_rvalid, 1);
    chk("t4_c_rd", c_rdata, 32'h12345678);

    // single-port back-to-back: grant every other cycle
    c_req = 1; c_we = 0; c_addr = 10'h010;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t5_c_gnt%0d", k), c_gnt, (k % 2 == 0));
      chk($sformatf("t5_c_rv%0d", k),  c_rvalid, (k % 2 == 1));
    end
    c_req = 0;
    tick();
    tick();

    // reset while a read is in flight
    c_req = 1; c_we = 0; c_addr = 10'h010;
    tick();
    chk("t6_c_gnt", c_gnt, 1);
    c_req = 0;
    rst = 1; d_req = 1; d_we = 0; d_addr = 10'h001;
    tick();
    chk("t6_rst_gnt",  {c_gnt, d_gnt}, 0);
    chk("t6_rst_rv",   {c_rvalid, d_rvalid}, 0);
    chk("t6_rst_en",   {mem_wren, mem_rden}, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wd",   mem_wdata, 0);
    chk("t6_rst_rd",   c_rdata | d_rdata, 0);
    rst = 0;
    c_req = 1;
    tick();
    chk("t6_tie_c", c_gnt, 1);
    chk("t6_tie_d", d_gnt, 0);
    chk("t6_no_rv", c_rvalid, 0);
    c_req = 0;
    tick();
    chk("t6_d_gnt", d_gnt, 1);
    chk("t6_c_rv",  c_rvalid, 1);
    chk("t6_c_rd",  c_rdata, 32'hDEADBEEF);
    d_req = 0;
    tick();
    chk("t6_d_rv", d_rvalid, 1);
    chk("t6_d_rd", d_rdata, 32'hA5A50001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 1K-word data memory between the CPU load/store path and a debug/loader port. It sits between the CPU datapath's memory request signals and the data memory. It serialises requests with round-robin fairness and registers the memory command. It returns read data to the requester that issued the read, with a fixed latency.

## Interface
- AW, 10: word-address width (1K words).
- DW, 32: data width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- c_req  in  1  CPU request valid; held until c_gnt.
- c_we  in  1  CPU request is a write (1) or a read (0).
- c_addr  in  AW  CPU word address.
- c_wdata  in  DW  CPU write data.
- c_gnt  out  1  one-cycle pulse: the CPU request has been issued to memory.
- c_rvalid  out  1  one-cycle pulse: c_rdata holds CPU read data.
- c_rdata  out  DW  CPU read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: identical set for the debug/loader port.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered memory write data.
- mem_wren  out  1  registered write enable.
- mem_rden  out  1  registered read enable.
- mem_q  in  DW  memory read data, valid the cycle after mem_rden.

## Operation
- Eligibility: a port is eligible in cycle T when x_req=1 and x_gnt=0 in T.
  - A request is never granted twice.
  - A requester drops its request, or presents its next transaction, in the cycle after its gnt.
- Arbitration (combinational, in T):
  - One eligible port: that port wins.
  - Both eligible: the port not granted most recently wins.
  - last_grant is a 1-bit register; reset value = debug, so the CPU wins the first tie.
- Issue (registered at the T/T+1 edge), in cycle T+1:
  - mem_addr, mem_wdata and mem_we/rden take the winner's fields.
  - Exactly one of mem_wren and mem_rden is 1.
  - The winner's x_gnt = 1 and last_grant updates.
- No winner: mem_wren = mem_rden = 0. mem_addr and mem_wdata hold their previous values.
- Read return:
  - A 1-bit tag and a valid bit are registered with each read issue and pipelined one stage.
  - In T+2 the tagged port's x_rvalid = 1 and x_rdata = mem_q.
  - The other port's rdata is 0.
- Writes produce no rvalid.
- Ordering: accesses reach memory in grant order. A read after a write to the same address, granted later, returns the new data.
- Throughput:
  - One memory access per cycle.
  - Both ports requesting continuously: grants alternate c, d, c, d.
  - Single requester: at most one grant every 2 cycles.

## Timing
- Reset: in the cycle after rst is sampled high, all of the following are 0:
  - c_gnt, d_gnt, c_rvalid, d_rvalid.
  - mem_wren, mem_rden, mem_addr, mem_wdata.
  - c_rdata, d_rdata.
  - last_grant = debug.
- Reset mid-operation: any read in flight is dropped, with no rvalid after reset. Requests present during rst are ignored. Arbitration resumes in the first cycle with rst=0.
- Latency:
  - Request sampled in T → gnt and memory command in T+1 → read data and rvalid in T+2.
  - Minimum request-to-data latency is 2 cycles.
- Stall: the CPU datapath stalls while c_req=1 and c_gnt=0. The arbiter adds no other wait state.
- Simultaneous events:
  - A gnt to one port and an rvalid to the other port may occur in the same cycle.
  - A new issue and a returning read may occur in the same cycle.
- Address is AW bits wide, so no out-of-range access is possible. Bounds checking is upstream.

## Test plan
- Reset then single CPU read:
  - Preload mem[0x010]=0xDEADBEEF.
  - c_req=1, c_we=0, c_addr=0x010 in cycle 1.
  - Required: c_gnt=1 and mem_rden=1 with mem_addr=0x010 in cycle 2.
  - Required: c_rvalid=1 and c_rdata=0xDEADBEEF in cycle 3. d_gnt and d_rvalid stay 0.
- Simultaneous requests from reset:
  - c read 0x001 and d write 0x002=0x55 both asserted, held until granted.
  - Required: CPU granted first, then debug in the next cycle.
  - Required: mem_wren=1 with mem_addr=0x002 in the debug cycle. c_rvalid arrives one cycle after c_gnt.
- Continuous contention:
  - Both ports re-request immediately after each gnt for 8 cycles.
  - Required: grants strictly alternate c, d, c, d…. Exactly one mem enable is 1 per cycle.
- Write-then-read ordering:
  - d writes 0x3FF=0x12345678.
  - c reads 0x3FF, requested in the cycle the debug write is issued.
  - Required: c_rdata=0x12345678.
- Single-port back-to-back:
  - CPU holds c_req=1 continuously for 6 cycles.
  - Required: c_gnt pattern 1,0,1,0,1,0 from the first grant. No double issue of the same request.
- Reset mid-read:
  - Assert rst in the cycle c_gnt=1 for a read.
  - Required: no c_rvalid afterward. All outputs are 0 the next cycle. After release, the next tie goes to the CPU.
